// File: rtl/bullet_link_tx.sv
// Frames bullet position/direction and hit events into SYNC-led byte frames for the UART TX.
// Define BULLET_LINK_CHECKSUM_EN to append an XOR checksum byte (5-byte frames instead of 4).
module bullet_link_tx #(
    parameter int unsigned FRAME_PERIOD = 650000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tank_hit,
    input  logic [9:0] xpos_bullet,
    input  logic [9:0] ypos_bullet,
    input  logic [2:0] direction,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       frame_sent,
    output logic       hit_pending
);

`ifdef BULLET_LINK_CHECKSUM_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif
    localparam int          TAIL_W      = (FRAME_BYTES - 1) * 8;
    localparam logic [2:0]  LAST_IDX    = 3'(FRAME_BYTES - 1);
    localparam logic [19:0] PERIOD_LAST = 20'(FRAME_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [19:0]       cnt_q, cnt_d;
    logic              tick_pending_q, tick_pending_d;
    logic              hit_pending_q, hit_pending_d;
    logic [2:0]        idx_q, idx_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              frame_sent_q, frame_sent_d;

    logic              tick;
    logic [7:0]        b1_w, b2_w, b3_w;
    logic [TAIL_W-1:0] latch_tail;

    // Free-running period counter; independent of enable and FSM state.
    assign tick  = (cnt_q == PERIOD_LAST);
    assign cnt_d = tick ? 20'd0 : cnt_q + 20'd1;

    assign b1_w = {hit_pending_q, direction, xpos_bullet[9:6]};
    assign b2_w = {xpos_bullet[5:0], ypos_bullet[9:8]};
    assign b3_w = ypos_bullet[7:0];

    // Bytes after SYNC, next-to-send in the top byte; shifted out as bytes are accepted.
`ifdef BULLET_LINK_CHECKSUM_EN
    assign latch_tail = {b1_w, b2_w, b3_w, SYNC_BYTE ^ b1_w ^ b2_w ^ b3_w};
`else
    assign latch_tail = {b1_w, b2_w, b3_w};
`endif

    // Byte handshake: a byte transfers on a cycle where tx_valid && tx_ready; while
    // tx_valid is high and tx_ready low, tx_data holds and tx_valid stays asserted.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tail_d         = tail_q;
        tx_valid_d     = tx_valid_q;
        tx_data_d      = tx_data_q;
        frame_sent_d   = 1'b0;
        tick_pending_d = tick_pending_q | tick;
        hit_pending_d  = hit_pending_q | tank_hit;

        case (state_q)
            ST_IDLE: begin
                if (enable && (tick_pending_q || hit_pending_q)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // A hit or tick landing in this same cycle belongs to the next frame.
                tick_pending_d = tick;
                hit_pending_d  = tank_hit;
                tail_d         = latch_tail;
                idx_d          = 3'd0;
                tx_valid_d     = 1'b1;
                tx_data_d      = SYNC_BYTE;
                state_d        = ST_SEND;
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d   = 1'b0;
                        tx_data_d    = 8'h00;
                        frame_sent_d = 1'b1;
                        idx_d        = 3'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = tail_q[TAIL_W-1 -: 8];
                        tail_d    = tail_q << 8;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 20'd0;
            tick_pending_q <= 1'b0;
            hit_pending_q  <= 1'b0;
            idx_q          <= 3'd0;
            tail_q         <= '0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            frame_sent_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tick_pending_q <= tick_pending_d;
            hit_pending_q  <= hit_pending_d;
            idx_q          <= idx_d;
            tail_q         <= tail_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            frame_sent_q   <= frame_sent_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign frame_sent  = frame_sent_q;
    assign hit_pending = hit_pending_q;

endmodule

// File: tb/tb_bullet_link_tx.sv
// Directed bench for bullet_link_tx with FRAME_PERIOD = 16; frame length follows BULLET_LINK_CHECKSUM_EN.
module tb_bullet_link_tx;

`ifdef BULLET_LINK_CHECKSUM_EN
    localparam int FRAME_N = 5;
`else
    localparam int FRAME_N = 4;
`endif

    // Hand-computed frames: b0..b4 (b4 only used with the checksum build).
    localparam logic [39:0] F_NOHIT = 40'hA5_3A_95_7F_75; // x=2A5 y=17F dir=3 hit=0
    localparam logic [39:0] F_HIT   = 40'hA5_BA_95_7F_F5; // x=2A5 y=17F dir=3 hit=1
    localparam logic [39:0] F_ALT   = 40'hA5_4F_FC_00_16; // x=3FF y=000 dir=4 hit=0

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       tank_hit;
    logic [9:0] xpos_bullet;
    logic [9:0] ypos_bullet;
    logic [2:0] direction;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       frame_sent;
    logic       hit_pending;

    int cyc        = 0;
    int checks     = 0;
    int failures   = 0;
    int seen_valid = 0;
    int start_at   = 0;

    always #5 clk = ~clk;

    bullet_link_tx #(
        .FRAME_PERIOD(16),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tank_hit   (tank_hit),
        .xpos_bullet(xpos_bullet),
        .ypos_bullet(ypos_bullet),
        .direction  (direction),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .frame_sent (frame_sent),
        .hit_pending(hit_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        tank_hit = 1'b0;
        tick_clk();
        tick_clk();
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            tick_clk();
            if (tx_valid === 1'b1) seen_valid++;
        end
    endtask

    task automatic wait_valid(output int at);
        int g;
        g = 0;
        while (tx_valid !== 1'b1 && g < 100) begin
            tick_clk();
            g++;
        end
        at = cyc;
    endtask

    // Checks each presented byte; bit c of ready_pat drives tx_ready in cycle c (mod 16).
    task automatic collect_frame(input string tag, input logic [39:0] exp,
                                 input logic [15:0] ready_pat,
                                 input int hit_at, input int en_drop_at);
        int k;
        int c;
        logic [39:0] sh;
        logic rdy;
        k  = 0;
        c  = 0;
        sh = exp;
        while (k < FRAME_N && c < 40) begin
            chk({tag, " valid"}, {31'd0, tx_valid}, 32'd1);
            chk({tag, " byte"}, {24'd0, tx_data}, {24'd0, sh[39:32]});
            rdy      = ready_pat[c % 16];
            tx_ready = rdy;
            if (c == hit_at) tank_hit = 1'b1;
            if (c == en_drop_at) enable = 1'b0;
            tick_clk();
            tank_hit = 1'b0;
            if (rdy) begin
                k++;
                sh = sh << 8;
            end
            c++;
        end
        tx_ready = 1'b1;
        chk({tag, " byte_count"}, k, FRAME_N);
        chk({tag, " frame_sent"}, {31'd0, frame_sent}, 32'd1);
        chk({tag, " valid_end"}, {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        enable      = 1'b0;
        tank_hit    = 1'b0;
        xpos_bullet = 10'h2A5;
        ypos_bullet = 10'h17F;
        direction   = 3'd3;
        tx_ready    = 1'b1;

        // Reset state
        tick_clk();
        tick_clk();
        chk("rst tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst frame_sent", {31'd0, frame_sent}, 32'd0);
        chk("rst hit_pending", {31'd0, hit_pending}, 32'd0);

        // Periodic frames: tick at edge 16, LATCH at 17, first byte after 18, next after 34
        enable = 1'b1;
        do_reset();
        run_to(17);
        chk("per pre_valid", {31'd0, tx_valid}, 32'd0);
        wait_valid(start_at);
        chk("per start1", start_at, 18);
        collect_frame("per f1", F_NOHIT, 16'hFFFF, -1, -1);
        chk("per sent_cyc", cyc, 18 + FRAME_N);
        tick_clk();
        chk("per sent_low", {31'd0, frame_sent}, 32'd0);
        wait_valid(start_at);
        chk("per start2", start_at, 34);
        collect_frame("per f2", F_NOHIT, 16'hFFFF, -1, -1);
        chk("per hit_pending", {31'd0, hit_pending}, 32'd0);

        // Hit in IDLE sampled at edge 3: tx_valid after edge 5, hit flag set
        do_reset();
        run_to(2);
        tank_hit = 1'b1;
        tick_clk();
        tank_hit = 1'b0;
        chk("hit pend_set", {31'd0, hit_pending}, 32'd1);
        chk("hit valid_n", {31'd0, tx_valid}, 32'd0);
        tick_clk();
        chk("hit valid_n1", {31'd0, tx_valid}, 32'd0);
        chk("hit pend_latch", {31'd0, hit_pending}, 32'd1);
        tick_clk();
        chk("hit valid_n2", {31'd0, tx_valid}, 32'd1);
        chk("hit pend_clear", {31'd0, hit_pending}, 32'd0);
        collect_frame("hit f", F_HIT, 16'hFFFF, -1, -1);

        // Stalls with ready 1,0,0,1; inputs changed after LATCH must not leak in
        xpos_bullet = 10'h3FF;
        ypos_bullet = 10'h000;
        direction   = 3'd4;
        do_reset();
        wait_valid(start_at);
        chk("stall start", start_at, 18);
        xpos_bullet = 10'h000;
        ypos_bullet = 10'h3FF;
        direction   = 3'd1;
        collect_frame("stall f", F_ALT, 16'h9999, -1, -1);
        xpos_bullet = 10'h2A5;
        ypos_bullet = 10'h17F;
        direction   = 3'd3;

        // Hit during SEND of a tick frame, another in the LATCH cycle of the next frame
        do_reset();
        wait_valid(start_at);
        chk("dbl startA", start_at, 18);
        collect_frame("dbl fA", F_NOHIT, 16'hFFFF, 1, -1);
        chk("dbl pend_after_A", {31'd0, hit_pending}, 32'd1);
        tick_clk();
        tank_hit = 1'b1;
        tick_clk();
        tank_hit = 1'b0;
        chk("dbl startB", cyc, 20 + FRAME_N);
        chk("dbl validB", {31'd0, tx_valid}, 32'd1);
        chk("dbl pend_kept", {31'd0, hit_pending}, 32'd1);
        collect_frame("dbl fB", F_HIT, 16'hFFFF, -1, -1);
        wait_valid(start_at);
        chk("dbl startC", start_at, 22 + 2 * FRAME_N);
        chk("dbl pend_C", {31'd0, hit_pending}, 32'd0);
        collect_frame("dbl fC", F_HIT, 16'hFFFF, -1, -1);

        // Disabled: ticks and a hit stay pending; one frame once enabled; drop enable mid-frame
        enable = 1'b0;
        do_reset();
        seen_valid = 0;
        run_to(2);
        tank_hit = 1'b1;
        tick_clk();
        tank_hit = 1'b0;
        run_to(40);
        chk("dis no_valid", seen_valid, 0);
        chk("dis pend_held", {31'd0, hit_pending}, 32'd1);
        enable = 1'b1;
        wait_valid(start_at);
        chk("dis start", start_at, 42);
        collect_frame("dis f", F_HIT, 16'hFFFF, -1, 1);
        chk("dis pend_clear", {31'd0, hit_pending}, 32'd0);
        seen_valid = 0;
        run_to(60);
        chk("dis no_more", seen_valid, 0);

        // Asynchronous reset mid-frame, then resync on SYNC_BYTE
        enable = 1'b1;
        do_reset();
        wait_valid(start_at);
        chk("arst start", start_at, 18);
        tank_hit = 1'b1;
        tick_clk();
        tank_hit = 1'b0;
        chk("arst mid_valid", {31'd0, tx_valid}, 32'd1);
        chk("arst mid_pend", {31'd0, hit_pending}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("arst tx_data", {24'd0, tx_data}, 32'd0);
        chk("arst hit_pending", {31'd0, hit_pending}, 32'd0);
        chk("arst frame_sent", {31'd0, frame_sent}, 32'd0);
        tick_clk();
        rst = 1'b1;
        cyc = 0;
        wait_valid(start_at);
        chk("arst restart", start_at, 18);
        collect_frame("arst f", F_NOHIT, 16'hFFFF, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bullet_link_tx.md
# bullet_link_tx

Frames the live bullet state and tank-hit events from the gun controller, and serialises them byte-by-byte to the inter-board UART transmitter so the opponent board can draw our bullet and register hits. It sits directly downstream of the gun controller, which supplies bullet position, direction code and the one-cycle hit pulse. It sits upstream of the UART TX, using a valid/ready byte handshake. Frames are sent periodically, and immediately on a hit.

## Interface
- FRAME_PERIOD, 650000: clock cycles between periodic frame requests (10 ms at 65 MHz); legal range 8..2^20-1.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  link enabled (player selected); gates frame starts only.
- tank_hit  in  1  one-cycle hit pulse from gun controller.
- xpos_bullet  in  10  bullet x, pixels.
- ypos_bullet  in  10  bullet y, pixels.
- direction  in  3  0 = no bullet, 1..4 = up/down/right/left.
- tx_ready  in  1  UART TX can accept a byte.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  8  byte to send.
- frame_sent  out  1  one-cycle pulse after last byte of a frame is accepted.
- hit_pending  out  1  a hit is captured but not yet latched into a frame.

## Operation
- Period counter: 20-bit, counts 0..FRAME_PERIOD-1 and wraps; `tick` is the cycle it equals FRAME_PERIOD-1. It runs regardless of enable and state. On tick, `tick_pending` is set. It is a single bit, so multiple ticks coalesce.
- tank_hit = 1 sets `hit_pending` (sticky).
- FSM states:
  - IDLE: if enable && (tick_pending || hit_pending), go to LATCH.
  - LATCH, one cycle: snapshot x, y and direction, plus hit flag = hit_pending. Clear tick_pending, and clear hit_pending unless tank_hit = 1 in this same cycle; in that case it stays set for the next frame. Build the frame. Byte index = 0. Go to SEND.
  - SEND: tx_valid = 1, tx_data = frame[index]. On tx_valid && tx_ready, index += 1. After the last byte is accepted, pulse frame_sent and go to IDLE.
- Frame byte layout:
  - b0 = SYNC_BYTE.
  - b1 = {hit, direction[2:0], x[9:6]}.
  - b2 = {x[5:0], y[9:8]}.
  - b3 = y[7:0].
  - b4 = b0^b1^b2^b3 (only when the checksum is compiled in).
- Inputs changing during SEND do not affect the frame in flight.
- enable dropping mid-frame does not abort; the frame completes. No new frame starts while enable = 0, and pending flags are held.
- A hit or tick arriving during SEND is kept pending; the next frame starts from IDLE on the cycle after returning.
- Reset mid-frame: everything returns to reset values immediately (asynchronously). The partial frame is abandoned, and the receiver resyncs on SYNC_BYTE.

## Timing
- Reset values: tx_valid 0, tx_data 8'h00, frame_sent 0, hit_pending 0, FSM IDLE, counter 0, tick_pending 0, byte index 0.
- All outputs are registered.
- tank_hit sampled at edge n (IDLE, enable = 1): hit_pending = 1 after edge n, LATCH after edge n+1, tx_valid = 1 and tx_data = SYNC_BYTE after edge n+2.
- With tx_ready held at 1, each byte lasts 1 cycle. A 5-byte frame occupies 5 SEND cycles; frame_sent is high the cycle after the final acceptance, coincident with IDLE.
- tx_data is stable while tx_valid = 1 and tx_ready = 0.
- Minimum spacing between frame starts is frame length + 2 cycles (SEND, then IDLE, then LATCH).

## Configuration
- BULLET_LINK_CHECKSUM_EN defined: 5-byte frames with XOR checksum byte b4.
- BULLET_LINK_CHECKSUM_EN undefined: 4-byte frames (b0..b3); no checksum logic is generated.

## Test plan
- Checksum on, FRAME_PERIOD = 16, enable = 1, tx_ready = 1, x = 10'h2A5, y = 10'h17F, direction = 3, no hit: bytes A5, 3A, 95, 7F, 75 appear; frame_sent pulses once; the next frame starts 16 cycles after the previous one.
- tank_hit pulse in IDLE: tx_valid rises 2 cycles after the sampled edge; b1[7] = 1; hit_pending is 0 after LATCH.
- tx_ready toggles 1,0,0,1: tx_data is held across the stalls; byte index advances only on accepted cycles; frame content is unchanged.
- tank_hit during SEND, and another exactly in the LATCH cycle: each hit yields its own subsequent frame with hit = 1; no hit is lost.
- enable = 0 while ticks and a hit occur: no tx_valid. Raise enable: exactly one frame with hit = 1 (ticks coalesced). Drop enable mid-frame: the frame still completes.
- Assert rst = 0 mid-frame (between clock edges): tx_valid, tx_data and hit_pending go to 0 immediately. After release, the first byte sent is SYNC_BYTE. Checksum off: frames are 4 bytes.
